// File: rtl/rx_drain_scheduler.sv
// rx_drain_scheduler: drains ping/pong receive buffers alternately into a registered valid/ready stream.
module rx_drain_scheduler #(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          CSRX,
  input  logic          Start,
  input  logic [CW-1:0] Burst,
  input  logic          LatchD0,
  input  logic          LatchD1,
  input  logic [DW-1:0] BUF0,
  input  logic [DW-1:0] BUF1,
  input  logic          ReadyRXOut,
  output logic [DW-1:0] RXOut,
  output logic          ValidRXOut,
  output logic          selBUF,
  output logic          Release0,
  output logic          Release1,
  output logic [CW-1:0] BurstCount,
  output logic          Busy,
  output logic          Done,
  output logic          Overrun
);
  typedef enum logic [1:0] {IDLE, WAIT, SEND, DONE} state_t;
  state_t state, state_nx;
  logic nxt, full0, full1;
  logic go, act, hs, clr0, clr1, full_sel;
  assign go = state == IDLE && Start;
  assign act = state == WAIT || state == SEND;
  assign hs = state == SEND && ReadyRXOut;
  assign clr0 = hs && !nxt;
  assign clr1 = hs && nxt;
  assign full_sel = nxt ? full1 : full0;
  assign Busy = state != IDLE;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (!CSRX) state_nx = IDLE;
    else if (state == IDLE) state_nx = Start ? (Burst == '0 ? DONE : WAIT) : IDLE;
    else if (state == WAIT) state_nx = full_sel ? SEND : WAIT;
    else if (state == SEND) state_nx = ReadyRXOut ? (BurstCount <= CW'(1) ? DONE : WAIT) : SEND;
    else state_nx = IDLE;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      nxt <= 1'b0;
      full0 <= 1'b0;
      full1 <= 1'b0;
      RXOut <= '0;
      ValidRXOut <= 1'b0;
      selBUF <= 1'b0;
      Release0 <= 1'b0;
      Release1 <= 1'b0;
      BurstCount <= '0;
      Done <= 1'b0;
      Overrun <= 1'b0;
    end else if (!CSRX) begin
      full0 <= 1'b0;
      full1 <= 1'b0;
      ValidRXOut <= 1'b0;
      Release0 <= 1'b0;
      Release1 <= 1'b0;
      BurstCount <= '0;
      Done <= 1'b0;
    end else begin
      Done <= state == DONE;
      Release0 <= clr0;
      Release1 <= clr1;
      if (go) begin
        BurstCount <= Burst;
        nxt <= 1'b0;
        full0 <= 1'b0;
        full1 <= 1'b0;
        Overrun <= 1'b0;
      end
      // a latch coinciding with the drain of the same buffer keeps it full
      if (act) begin
        full0 <= LatchD0 || (full0 && !clr0);
        full1 <= LatchD1 || (full1 && !clr1);
        if ((LatchD0 && full0 && !clr0) || (LatchD1 && full1 && !clr1)) Overrun <= 1'b1;
      end
      if (state == WAIT && full_sel) begin
        RXOut <= nxt ? BUF1 : BUF0;
        selBUF <= nxt;
        ValidRXOut <= 1'b1;
      end
      if (hs) begin
        ValidRXOut <= 1'b0;
        nxt <= ~nxt;
        if (BurstCount != '0) BurstCount <= BurstCount - CW'(1);
      end
    end
endmodule

// File: tb/tb_rx_drain_scheduler.sv
// tb_rx_drain_scheduler: directed scenario checks for rx_drain_scheduler.
module tb_rx_drain_scheduler;
  logic clock = 1'b0, resetn = 1'b0, CSRX = 1'b0, Start = 1'b0;
  logic [5:0] Burst = '0;
  logic LatchD0 = 1'b0, LatchD1 = 1'b0, ReadyRXOut = 1'b0;
  logic [31:0] BUF0 = '0, BUF1 = '0;
  logic [31:0] RXOut;
  logic ValidRXOut, selBUF, Release0, Release1, Busy, Done, Overrun;
  logic [5:0] BurstCount;
  int passed = 0, total = 0;

  rx_drain_scheduler #(.DW(32), .CW(6)) dut (
    .clock(clock), .resetn(resetn), .CSRX(CSRX), .Start(Start), .Burst(Burst),
    .LatchD0(LatchD0), .LatchD1(LatchD1), .BUF0(BUF0), .BUF1(BUF1),
    .ReadyRXOut(ReadyRXOut), .RXOut(RXOut), .ValidRXOut(ValidRXOut), .selBUF(selBUF),
    .Release0(Release0), .Release1(Release1), .BurstCount(BurstCount), .Busy(Busy),
    .Done(Done), .Overrun(Overrun)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic abort();
    CSRX = 1'b0;
    tick();
    CSRX = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    total++; if ({RXOut, ValidRXOut, selBUF} !== 34'h0) $display("FAIL reset_data got=%0h exp=0", {RXOut, ValidRXOut, selBUF}); else passed++;
    total++; if ({Release0, Release1, Busy, Done, Overrun} !== 5'b0) $display("FAIL reset_flags got=%b exp=00000", {Release0, Release1, Busy, Done, Overrun}); else passed++;
    total++; if (BurstCount !== 6'd0) $display("FAIL reset_count got=%0d exp=0", BurstCount); else passed++;
    resetn = 1'b1;
    CSRX = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    ReadyRXOut = 1'b1;
    Start = 1'b1; Burst = 6'd3;
    tick();
    Start = 1'b0;
    total++; if ({Busy, BurstCount} !== {1'b1, 6'd3}) $display("FAIL basic_start got=%0h exp=%0h", {Busy, BurstCount}, {1'b1, 6'd3}); else passed++;
    BUF0 = 32'hA5A5A5A5; LatchD0 = 1'b1;
    tick();
    LatchD0 = 1'b0;
    total++; if (ValidRXOut !== 1'b0) $display("FAIL basic_latency got=%b exp=0", ValidRXOut); else passed++;
    tick();
    total++; if ({ValidRXOut, selBUF, RXOut} !== {2'b10, 32'hA5A5A5A5}) $display("FAIL basic_w0 got=%0h exp=%0h", {ValidRXOut, selBUF, RXOut}, {2'b10, 32'hA5A5A5A5}); else passed++;
    tick();
    total++; if ({ValidRXOut, Release0, Release1, BurstCount} !== {3'b010, 6'd2}) $display("FAIL basic_hs0 got=%0h exp=%0h", {ValidRXOut, Release0, Release1, BurstCount}, {3'b010, 6'd2}); else passed++;
    BUF1 = 32'h11223344; LatchD1 = 1'b1;
    tick();
    LatchD1 = 1'b0;
    total++; if (Release0 !== 1'b0) $display("FAIL basic_rel0_pulse got=%b exp=0", Release0); else passed++;
    tick();
    total++; if ({ValidRXOut, selBUF, RXOut} !== {2'b11, 32'h11223344}) $display("FAIL basic_w1 got=%0h exp=%0h", {ValidRXOut, selBUF, RXOut}, {2'b11, 32'h11223344}); else passed++;
    tick();
    total++; if ({ValidRXOut, Release0, Release1, BurstCount} !== {3'b001, 6'd1}) $display("FAIL basic_hs1 got=%0h exp=%0h", {ValidRXOut, Release0, Release1, BurstCount}, {3'b001, 6'd1}); else passed++;
    BUF0 = 32'hDEADBEEF; LatchD0 = 1'b1;
    tick();
    LatchD0 = 1'b0;
    tick();
    total++; if ({ValidRXOut, selBUF, RXOut} !== {2'b10, 32'hDEADBEEF}) $display("FAIL basic_w2 got=%0h exp=%0h", {ValidRXOut, selBUF, RXOut}, {2'b10, 32'hDEADBEEF}); else passed++;
    tick();
    total++; if ({Release0, BurstCount, Busy, Done} !== {1'b1, 6'd0, 2'b10}) $display("FAIL basic_hs2 got=%0h exp=%0h", {Release0, BurstCount, Busy, Done}, {1'b1, 6'd0, 2'b10}); else passed++;
    tick();
    total++; if ({Done, Busy, Release0} !== 3'b100) $display("FAIL basic_done got=%b exp=100", {Done, Busy, Release0}); else passed++;
    tick();
    total++; if (Done !== 1'b0) $display("FAIL basic_done_pulse got=%b exp=0", Done); else passed++;
    ReadyRXOut = 1'b0;
  endtask

  task automatic test_backpressure();
    Start = 1'b1; Burst = 6'd2;
    tick();
    Start = 1'b0;
    BUF0 = 32'h12345678; LatchD0 = 1'b1;
    tick();
    LatchD0 = 1'b0;
    tick();
    BUF0 = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({ValidRXOut, RXOut, BurstCount, Release0} !== {1'b1, 32'h12345678, 6'd2, 1'b0}) $display("FAIL stall_hold%0d got=%0h exp=%0h", i, {ValidRXOut, RXOut, BurstCount, Release0}, {1'b1, 32'h12345678, 6'd2, 1'b0}); else passed++;
    end
    ReadyRXOut = 1'b1;
    tick();
    ReadyRXOut = 1'b0;
    total++; if ({ValidRXOut, Release0, BurstCount} !== {2'b01, 6'd1}) $display("FAIL stall_hs got=%0h exp=%0h", {ValidRXOut, Release0, BurstCount}, {2'b01, 6'd1}); else passed++;
    tick();
    total++; if ({Release0, BurstCount} !== {1'b0, 6'd1}) $display("FAIL stall_once got=%0h exp=%0h", {Release0, BurstCount}, {1'b0, 6'd1}); else passed++;
    abort();
  endtask

  task automatic test_overrun();
    Start = 1'b1; Burst = 6'd2;
    tick();
    Start = 1'b0;
    BUF0 = 32'hCAFE0001; LatchD0 = 1'b1;
    tick();
    LatchD0 = 1'b0;
    tick();
    total++; if (Overrun !== 1'b0) $display("FAIL ovr_clear_before got=%b exp=0", Overrun); else passed++;
    BUF0 = 32'hCAFE0002; LatchD0 = 1'b1;
    tick();
    LatchD0 = 1'b0;
    total++; if ({Overrun, ValidRXOut, RXOut} !== {2'b11, 32'hCAFE0001}) $display("FAIL ovr_set got=%0h exp=%0h", {Overrun, ValidRXOut, RXOut}, {2'b11, 32'hCAFE0001}); else passed++;
    ReadyRXOut = 1'b1;
    tick();
    ReadyRXOut = 1'b0;
    total++; if ({Overrun, Release0} !== 2'b11) $display("FAIL ovr_after_hs got=%b exp=11", {Overrun, Release0}); else passed++;
    abort();
    tick();
    total++; if ({Overrun, Busy} !== 2'b10) $display("FAIL ovr_sticky_idle got=%b exp=10", {Overrun, Busy}); else passed++;
    Start = 1'b1; Burst = 6'd1;
    tick();
    Start = 1'b0;
    total++; if ({Overrun, BurstCount} !== {1'b0, 6'd1}) $display("FAIL ovr_start_clear got=%0h exp=%0h", {Overrun, BurstCount}, {1'b0, 6'd1}); else passed++;
    abort();
  endtask

  task automatic test_order();
    ReadyRXOut = 1'b1;
    Start = 1'b1; Burst = 6'd2;
    tick();
    Start = 1'b0;
    BUF1 = 32'hB1B1B1B1; LatchD1 = 1'b1;
    tick();
    LatchD1 = 1'b0;
    tick();
    tick();
    total++; if (ValidRXOut !== 1'b0) $display("FAIL order_wait_buf0 got=%b exp=0", ValidRXOut); else passed++;
    BUF0 = 32'hA0A0A0A0; LatchD0 = 1'b1;
    tick();
    LatchD0 = 1'b0;
    tick();
    total++; if ({ValidRXOut, selBUF, RXOut} !== {2'b10, 32'hA0A0A0A0}) $display("FAIL order_first got=%0h exp=%0h", {ValidRXOut, selBUF, RXOut}, {2'b10, 32'hA0A0A0A0}); else passed++;
    tick();
    total++; if ({ValidRXOut, Release0} !== 2'b01) $display("FAIL order_hs0 got=%b exp=01", {ValidRXOut, Release0}); else passed++;
    tick();
    total++; if ({ValidRXOut, selBUF, RXOut} !== {2'b11, 32'hB1B1B1B1}) $display("FAIL order_second got=%0h exp=%0h", {ValidRXOut, selBUF, RXOut}, {2'b11, 32'hB1B1B1B1}); else passed++;
    tick();
    tick();
    total++; if ({Done, BurstCount} !== {1'b1, 6'd0}) $display("FAIL order_done got=%0h exp=%0h", {Done, BurstCount}, {1'b1, 6'd0}); else passed++;
    ReadyRXOut = 1'b0;
    tick();
  endtask

  task automatic test_set_wins();
    Start = 1'b1; Burst = 6'd3;
    tick();
    Start = 1'b0;
    BUF0 = 32'h00000AAA; LatchD0 = 1'b1;
    tick();
    LatchD0 = 1'b0;
    tick();
    ReadyRXOut = 1'b1; BUF0 = 32'h00000CCC; LatchD0 = 1'b1;
    tick();
    LatchD0 = 1'b0;
    total++; if ({Overrun, Release0, BurstCount} !== {2'b01, 6'd2}) $display("FAIL setwin_no_ovr got=%0h exp=%0h", {Overrun, Release0, BurstCount}, {2'b01, 6'd2}); else passed++;
    BUF1 = 32'h00000BBB; LatchD1 = 1'b1;
    tick();
    LatchD1 = 1'b0;
    tick();
    total++; if ({selBUF, RXOut} !== {1'b1, 32'h00000BBB}) $display("FAIL setwin_w1 got=%0h exp=%0h", {selBUF, RXOut}, {1'b1, 32'h00000BBB}); else passed++;
    tick();
    tick();
    total++; if ({ValidRXOut, selBUF, RXOut} !== {2'b10, 32'h00000CCC}) $display("FAIL setwin_kept got=%0h exp=%0h", {ValidRXOut, selBUF, RXOut}, {2'b10, 32'h00000CCC}); else passed++;
    tick();
    tick();
    total++; if ({Done, Overrun} !== 2'b10) $display("FAIL setwin_done got=%b exp=10", {Done, Overrun}); else passed++;
    ReadyRXOut = 1'b0;
    tick();
  endtask

  task automatic test_zero_burst();
    Start = 1'b1; Burst = 6'd0;
    tick();
    Start = 1'b0;
    total++; if ({Busy, Done, ValidRXOut, BurstCount} !== {3'b100, 6'd0}) $display("FAIL zero_state got=%0h exp=%0h", {Busy, Done, ValidRXOut, BurstCount}, {3'b100, 6'd0}); else passed++;
    tick();
    total++; if ({Done, Busy, ValidRXOut} !== 3'b100) $display("FAIL zero_done got=%b exp=100", {Done, Busy, ValidRXOut}); else passed++;
    tick();
    total++; if ({Done, ValidRXOut} !== 2'b00) $display("FAIL zero_done_pulse got=%b exp=00", {Done, ValidRXOut}); else passed++;
  endtask

  task automatic test_abort();
    Start = 1'b1; Burst = 6'd3;
    tick();
    Start = 1'b0;
    BUF0 = 32'h0BADF00D; LatchD0 = 1'b1;
    tick();
    LatchD0 = 1'b0;
    tick();
    total++; if (ValidRXOut !== 1'b1) $display("FAIL abort_in_send got=%b exp=1", ValidRXOut); else passed++;
    CSRX = 1'b0;
    tick();
    total++; if ({Busy, ValidRXOut, Done, Release0, BurstCount} !== {4'b0000, 6'd0}) $display("FAIL abort_csrx got=%0h exp=0", {Busy, ValidRXOut, Done, Release0, BurstCount}); else passed++;
    CSRX = 1'b1;
    tick();
    total++; if ({Busy, Done} !== 2'b00) $display("FAIL abort_no_done got=%b exp=00", {Busy, Done}); else passed++;
    Start = 1'b1; Burst = 6'd2;
    tick();
    Start = 1'b0;
    LatchD0 = 1'b1;
    tick();
    LatchD0 = 1'b0;
    tick();
    #2 resetn = 1'b0;
    #1;
    total++; if ({Busy, ValidRXOut, BurstCount} !== {2'b00, 6'd0}) $display("FAIL abort_async_reset got=%0h exp=0", {Busy, ValidRXOut, BurstCount}); else passed++;
    tick();
    resetn = 1'b1;
    tick();
    total++; if ({Busy, Done, ValidRXOut} !== 3'b000) $display("FAIL abort_after_reset got=%b exp=000", {Busy, Done, ValidRXOut}); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_order();
    test_set_wins();
    test_zero_burst();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
